// File: rtl/pcileech_ft601_emu_if.sv
// Bundle of FT601 pad signals plus the host-side word streams for the FT601
// emulator.
//   master : FPGA design under emulation and host model. Drives the strobes,
//            write data/byte enables, host RX words and host TX ready.
//   slave  : emulator. Drives read data, bus enable, the RXF/TXE flags,
//            host RX ready and the host TX word stream.
interface pcileech_ft601_emu_if;
  logic        ft601_rst_n;
  logic [31:0] ft601_data_i;
  logic [3:0]  ft601_be_i;
  logic [31:0] ft601_data_o;
  logic        ft601_data_oe;
  logic        ft601_rxf_n;
  logic        ft601_txe_n;
  logic        ft601_wr_n;
  logic        ft601_rd_n;
  logic        ft601_oe_n;
  logic        ft601_siwu_n;
  logic [31:0] host_rx_data;
  logic        host_rx_valid;
  logic        host_rx_ready;
  logic [31:0] host_tx_data;
  logic [3:0]  host_tx_be;
  logic        host_tx_valid;
  logic        host_tx_ready;

  modport master (
    output ft601_rst_n, ft601_data_i, ft601_be_i, ft601_wr_n, ft601_rd_n,
           ft601_oe_n, ft601_siwu_n, host_rx_data, host_rx_valid, host_tx_ready,
    input  ft601_data_o, ft601_data_oe, ft601_rxf_n, ft601_txe_n,
           host_rx_ready, host_tx_data, host_tx_be, host_tx_valid
  );

  modport slave (
    input  ft601_rst_n, ft601_data_i, ft601_be_i, ft601_wr_n, ft601_rd_n,
           ft601_oe_n, ft601_siwu_n, host_rx_data, host_rx_valid, host_tx_ready,
    output ft601_data_o, ft601_data_oe, ft601_rxf_n, ft601_txe_n,
           host_rx_ready, host_tx_data, host_tx_be, host_tx_valid
  );
endinterface

// File: rtl/pcileech_ft601_emu.sv
// Behavioural FT601 245-FIFO emulator. A host->FPGA FIFO (RX) is filled from
// the host word stream and drained across the pads by OE#/RD# reads; an
// FPGA->host FIFO (TX, data+byte enables) is filled by WR# writes and drained
// by the host word stream.
// Ports:
//   clk, rst_n     : bus clock, asynchronous active-low reset
//   bus (slave)    : FT601 pads and host streams, see pcileech_ft601_emu_if
//   rx_word_count  : words read across the pads (wraps)
//   tx_word_count  : words written across the pads (wraps)
//   proto_err      : sticky strobe-combination violation flag
module pcileech_ft601_emu #(
  parameter int PARAM_RX_DEPTH_LOG2 = 6,
  parameter int PARAM_TX_DEPTH_LOG2 = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  pcileech_ft601_emu_if.slave bus,
  output logic [31:0]         rx_word_count,
  output logic [31:0]         tx_word_count,
  output logic                proto_err
);
  localparam int RXA = PARAM_RX_DEPTH_LOG2;
  localparam int TXA = PARAM_TX_DEPTH_LOG2;
  localparam logic [RXA:0] RX_DEPTH = (RXA+1)'(1 << RXA);
  localparam logic [TXA:0] TX_DEPTH = (TXA+1)'(1 << TXA);

  logic [31:0]    r_rx_mem [1 << RXA];
  logic [RXA-1:0] r_rx_wptr;
  logic [RXA-1:0] r_rx_rptr;
  logic [RXA:0]   r_rx_cnt;
  logic           r_rxf_n;
  logic           r_rx_ready;

  logic [35:0]    r_tx_mem [1 << TXA];
  logic [TXA-1:0] r_tx_wptr;
  logic [TXA-1:0] r_tx_rptr;
  logic [TXA:0]   r_tx_cnt;
  logic           r_txe_n;

  logic           r_data_oe;
  logic           r_proto_err;
  logic [31:0]    r_rx_words;
  logic [31:0]    r_tx_words;

  logic           w_rd_act;
  logic           w_wr_act;
  logic           w_rx_push;
  logic           w_rx_pop;
  logic           w_tx_push;
  logic           w_tx_pop;
  logic           w_err_set;
  logic [RXA:0]   w_rx_cnt_nxt;
  logic [TXA:0]   w_tx_cnt_nxt;
  logic           w_unused_siwu;

  // Strobes only count while the matching flag is asserted; a strobe seen
  // against a deasserted flag is neither a transfer nor a violation.
  assign w_rd_act  = bus.ft601_rst_n & ~bus.ft601_rd_n & ~r_rxf_n;
  assign w_wr_act  = bus.ft601_rst_n & ~bus.ft601_wr_n & ~r_txe_n;
  assign w_err_set = (w_wr_act & ~bus.ft601_oe_n) | (w_rd_act & bus.ft601_oe_n);

  assign w_rx_push = bus.ft601_rst_n & bus.host_rx_valid & r_rx_ready & (r_rx_cnt != RX_DEPTH);
  assign w_rx_pop  = w_rd_act & ~bus.ft601_oe_n & (r_rx_cnt != '0);
  assign w_tx_push = w_wr_act & (r_tx_cnt != TX_DEPTH);
  assign w_tx_pop  = bus.ft601_rst_n & bus.host_tx_ready & (r_tx_cnt != '0);

  assign w_rx_cnt_nxt = r_rx_cnt + (RXA+1)'(w_rx_push) - (RXA+1)'(w_rx_pop);
  assign w_tx_cnt_nxt = r_tx_cnt + (TXA+1)'(w_tx_push) - (TXA+1)'(w_tx_pop);

  // FIFO storage carries data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= bus.host_rx_data;
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= {bus.ft601_be_i, bus.ft601_data_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_wptr   <= '0;
      r_rx_rptr   <= '0;
      r_rx_cnt    <= '0;
      r_rxf_n     <= 1'b1;
      r_rx_ready  <= 1'b0;
      r_tx_wptr   <= '0;
      r_tx_rptr   <= '0;
      r_tx_cnt    <= '0;
      r_txe_n     <= 1'b1;
      r_data_oe   <= 1'b0;
      r_proto_err <= 1'b0;
      r_rx_words  <= '0;
      r_tx_words  <= '0;
    end else if (!bus.ft601_rst_n) begin
      // Chip reset flushes everything except the sticky error flag.
      r_rx_wptr   <= '0;
      r_rx_rptr   <= '0;
      r_rx_cnt    <= '0;
      r_rxf_n     <= 1'b1;
      r_rx_ready  <= 1'b0;
      r_tx_wptr   <= '0;
      r_tx_rptr   <= '0;
      r_tx_cnt    <= '0;
      r_txe_n     <= 1'b1;
      r_data_oe   <= 1'b0;
      r_rx_words  <= '0;
      r_tx_words  <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      // Flags look at the post-edge count so they are exact in the next cycle.
      r_rxf_n    <= (w_rx_cnt_nxt == '0);
      r_rx_ready <= (w_rx_cnt_nxt != RX_DEPTH);
      r_txe_n    <= (w_tx_cnt_nxt == TX_DEPTH);
      r_data_oe  <= ~bus.ft601_oe_n;
      if (w_rx_pop)  r_rx_words <= r_rx_words + 32'd1;
      if (w_tx_push) r_tx_words <= r_tx_words + 32'd1;
      if (w_err_set) r_proto_err <= 1'b1;
    end
  end

  // Read data is the FIFO head; forced to zero when nothing is queued.
  assign bus.ft601_data_o  = (r_rx_cnt != '0) ? r_rx_mem[r_rx_rptr] : 32'h0;
  assign bus.ft601_data_oe = r_data_oe;
  assign bus.ft601_rxf_n   = r_rxf_n;
  assign bus.ft601_txe_n   = r_txe_n;
  assign bus.host_rx_ready = r_rx_ready;
  assign bus.host_tx_data  = r_tx_mem[r_tx_rptr][31:0];
  assign bus.host_tx_be    = r_tx_mem[r_tx_rptr][35:32];
  assign bus.host_tx_valid = (r_tx_cnt != '0);
  assign rx_word_count     = r_rx_words;
  assign tx_word_count     = r_tx_words;
  assign proto_err         = r_proto_err;

  // SIWU# has no effect in this emulation.
  assign w_unused_siwu = bus.ft601_siwu_n;
endmodule

// File: tb/tb_pcileech_ft601_emu.sv
module tb_pcileech_ft601_emu;
  localparam int RXL = 6;
  localparam int TXL = 6;
  localparam int RXD = 1 << RXL;
  localparam int TXD = 1 << TXL;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rx_word_count;
  logic [31:0] tx_word_count;
  logic        proto_err;

  int n_checks = 0;
  int n_errs   = 0;

  pcileech_ft601_emu_if ifc ();

  pcileech_ft601_emu #(
    .PARAM_RX_DEPTH_LOG2(RXL),
    .PARAM_TX_DEPTH_LOG2(TXL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (ifc),
    .rx_word_count (rx_word_count),
    .tx_word_count (tx_word_count),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two plain queues plus the externally visible state.
  logic [31:0] m_rxq [$];
  logic [35:0] m_txq [$];
  bit          m_flushed = 1'b1;  // flags still in their post-reset/flush state
  bit          m_err     = 1'b0;
  bit          m_oe      = 1'b0;
  logic [31:0] m_rxw     = '0;
  logic [31:0] m_txw     = '0;
  bit          mon_fl, mon_rx_pu, mon_rx_po, mon_tx_pu, mon_tx_po;
  bit          mon_rxf_low, mon_txe_low, mon_ready;

  task automatic model_clear();
    m_rxq.delete();
    m_txq.delete();
    m_flushed = 1'b1;
    m_oe      = 1'b0;
    m_rxw     = '0;
    m_txw     = '0;
  endtask

  // Monitor / scoreboard: on each falling edge compare what the DUT shows
  // with the model, then advance the model by what the next rising edge does.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_clear();
      m_err = 1'b0;
    end
    mon_rxf_low = (m_rxq.size() != 0);
    mon_txe_low = !m_flushed && (m_txq.size() != TXD);
    mon_ready   = !m_flushed && (m_rxq.size() < RXD);
    chk("rxf_n",         64'(ifc.ft601_rxf_n),   64'(!mon_rxf_low));
    chk("txe_n",         64'(ifc.ft601_txe_n),   64'(!mon_txe_low));
    chk("host_rx_ready", 64'(ifc.host_rx_ready), 64'(mon_ready));
    chk("host_tx_valid", 64'(ifc.host_tx_valid), 64'(m_txq.size() != 0));
    chk("data_o",        64'(ifc.ft601_data_o),  64'((m_rxq.size() != 0) ? m_rxq[0] : 32'h0));
    chk("data_oe",       64'(ifc.ft601_data_oe), 64'(m_oe));
    chk("rx_word_count", 64'(rx_word_count),     64'(m_rxw));
    chk("tx_word_count", 64'(tx_word_count),     64'(m_txw));
    chk("proto_err",     64'(proto_err),         64'(m_err));
    if (rst_n) begin
      mon_fl    = ifc.ft601_rst_n;
      mon_rx_pu = mon_fl && ifc.host_rx_valid && mon_ready;
      mon_rx_po = mon_fl && mon_rxf_low && !ifc.ft601_oe_n && !ifc.ft601_rd_n;
      mon_tx_pu = mon_fl && mon_txe_low && !ifc.ft601_wr_n;
      mon_tx_po = mon_fl && ifc.host_tx_ready && (m_txq.size() != 0);
      if (mon_fl && ((!ifc.ft601_wr_n && mon_txe_low && !ifc.ft601_oe_n) ||
                     (!ifc.ft601_rd_n && mon_rxf_low && ifc.ft601_oe_n)))
        m_err = 1'b1;
      if (mon_rx_po) begin
        chk("rx_pad_word", 64'(ifc.ft601_data_o), 64'(m_rxq.pop_front()));
        m_rxw = m_rxw + 32'd1;
      end
      if (mon_tx_po)
        chk("tx_host_word", 64'({ifc.host_tx_be, ifc.host_tx_data}), 64'(m_txq.pop_front()));
      if (mon_rx_pu) m_rxq.push_back(ifc.host_rx_data);
      if (mon_tx_pu) begin
        m_txq.push_back({ifc.ft601_be_i, ifc.ft601_data_i});
        m_txw = m_txw + 32'd1;
      end
      m_oe = mon_fl && !ifc.ft601_oe_n;
      if (!mon_fl) model_clear();
      else         m_flushed = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.ft601_rst_n   = 1'b1;
    ifc.ft601_data_i  = '0;
    ifc.ft601_be_i    = '0;
    ifc.ft601_wr_n    = 1'b1;
    ifc.ft601_rd_n    = 1'b1;
    ifc.ft601_oe_n    = 1'b1;
    ifc.ft601_siwu_n  = 1'b1;
    ifc.host_rx_data  = '0;
    ifc.host_rx_valid = 1'b0;
    ifc.host_tx_ready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rxf_n"},  64'(ifc.ft601_rxf_n),   64'(1));
    chk({tag, "_txe_n"},  64'(ifc.ft601_txe_n),   64'(1));
    chk({tag, "_oe"},     64'(ifc.ft601_data_oe), 64'(0));
    chk({tag, "_ready"},  64'(ifc.host_rx_ready), 64'(0));
    chk({tag, "_valid"},  64'(ifc.host_tx_valid), 64'(0));
    chk({tag, "_data_o"}, 64'(ifc.ft601_data_o),  64'(0));
    chk({tag, "_rxcnt"},  64'(rx_word_count),     64'(0));
    chk({tag, "_txcnt"},  64'(tx_word_count),     64'(0));
    chk({tag, "_err"},    64'(proto_err),         64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] words [3];
    int          rd_pct, tx_pct, wr_pct;
    words[0] = 32'h11111111;
    words[1] = 32'h22222222;
    words[2] = 32'h33333333;

    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("por");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    chk("first_txe_n",  64'(ifc.ft601_txe_n),   64'(0));
    chk("first_rxf_n",  64'(ifc.ft601_rxf_n),   64'(1));
    chk("first_ready",  64'(ifc.host_rx_ready), 64'(1));

    // Three host words read back across the pads.
    ifc.host_rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifc.host_rx_data = words[i];
      step();
    end
    ifc.host_rx_valid = 1'b0;
    ifc.ft601_oe_n = 1'b0;
    ifc.ft601_rd_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("burst_head", 64'(ifc.ft601_data_o), 64'(words[i]));
      step();
    end
    chk("burst_rxf_high", 64'(ifc.ft601_rxf_n), 64'(1));
    step();
    ifc.ft601_oe_n = 1'b1;
    step();
    chk("burst_rx_count", 64'(rx_word_count), 64'(3));
    // RD# with OE# high while RX is empty is not a violation.
    step();
    ifc.ft601_rd_n = 1'b1;
    step();
    chk("rd_while_empty_err", 64'(proto_err), 64'(0));

    // Fill TX with the host stalled; the 65th strobe is ignored.
    ifc.ft601_wr_n = 1'b0;
    for (int i = 0; i <= TXD; i++) begin
      ifc.ft601_data_i = 32'hA0000000 + i;
      ifc.ft601_be_i   = 4'(i);
      step();
      if (i == TXD - 2) chk("fill_txe_n_63", 64'(ifc.ft601_txe_n), 64'(0));
      if (i == TXD - 1) chk("fill_txe_n_64", 64'(ifc.ft601_txe_n), 64'(1));
    end
    chk("fill_tx_count", 64'(tx_word_count), 64'(TXD));

    // Full FIFO, host drains while FPGA keeps writing for 200 strobes.
    ifc.host_tx_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ifc.ft601_data_i = 32'hB0000000 + i;
      ifc.ft601_be_i   = 4'(i + 3);
      step();
      if (i >= 1) chk("stream_txe_n", 64'(ifc.ft601_txe_n), 64'(0));
    end
    ifc.ft601_wr_n = 1'b1;
    chk("stream_tx_count", 64'(tx_word_count), 64'(TXD + 199));
    repeat (TXD + 4) step();
    chk("drained_valid", 64'(ifc.host_tx_valid), 64'(0));

    // WR# together with OE# sets the sticky error.
    ifc.ft601_wr_n = 1'b0;
    ifc.ft601_oe_n = 1'b0;
    step();
    ifc.ft601_wr_n = 1'b1;
    ifc.ft601_oe_n = 1'b1;
    step();
    chk("proto_err_set", 64'(proto_err), 64'(1));
    repeat (5) step();
    chk("proto_err_sticky", 64'(proto_err), 64'(1));

    // Chip reset with ten words queued in each direction.
    ifc.host_tx_ready = 1'b0;
    ifc.host_rx_valid = 1'b1;
    ifc.ft601_wr_n    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ifc.host_rx_data = $urandom;
      ifc.ft601_data_i = $urandom;
      step();
    end
    ifc.host_rx_valid = 1'b0;
    ifc.ft601_wr_n    = 1'b1;
    step();
    chk("pre_flush_rxf", 64'(ifc.ft601_rxf_n),   64'(0));
    chk("pre_flush_val", 64'(ifc.host_tx_valid), 64'(1));
    ifc.ft601_rst_n = 1'b0;
    step();
    ifc.ft601_rst_n = 1'b1;
    chk("flush_rxf_n",  64'(ifc.ft601_rxf_n),   64'(1));
    chk("flush_txe_n",  64'(ifc.ft601_txe_n),   64'(1));
    chk("flush_valid",  64'(ifc.host_tx_valid), 64'(0));
    chk("flush_ready",  64'(ifc.host_rx_ready), 64'(0));
    chk("flush_rxcnt",  64'(rx_word_count),     64'(0));
    chk("flush_txcnt",  64'(tx_word_count),     64'(0));
    chk("flush_err",    64'(proto_err),         64'(1));
    step();
    chk("post_flush_txe", 64'(ifc.ft601_txe_n),   64'(0));
    chk("post_flush_rdy", 64'(ifc.host_rx_ready), 64'(1));

    // Asynchronous reset in the middle of a read/write burst.
    ifc.host_rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ifc.host_rx_data = 32'hC0000000 + i;
      step();
    end
    ifc.ft601_oe_n = 1'b0;
    ifc.ft601_rd_n = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    idle_inputs();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    chk("rel_rxf_n",  64'(ifc.ft601_rxf_n),  64'(1));
    chk("rel_data_o", 64'(ifc.ft601_data_o), 64'(0));
    chk("rel_txe_n",  64'(ifc.ft601_txe_n),  64'(0));

    // Randomized traffic with varying read/drain/write pressure.
    for (int ph = 0; ph < 4; ph++) begin
      rd_pct = (ph == 0) ? 10 : (ph == 1) ? 90 : 50;
      tx_pct = (ph == 2) ? 10 : (ph == 3) ? 95 : 60;
      wr_pct = (ph == 3) ? 30 : 70;
      for (int c = 0; c < 800; c++) begin
        ifc.host_rx_valid = ($urandom_range(0, 99) < 70);
        ifc.host_rx_data  = $urandom;
        ifc.ft601_oe_n    = ($urandom_range(0, 99) >= rd_pct + 5);
        ifc.ft601_rd_n    = ($urandom_range(0, 99) >= rd_pct);
        ifc.ft601_wr_n    = ($urandom_range(0, 99) >= wr_pct);
        ifc.ft601_data_i  = $urandom;
        ifc.ft601_be_i    = 4'($urandom_range(0, 15));
        ifc.host_tx_ready = ($urandom_range(0, 99) < tx_pct);
        ifc.ft601_rst_n   = ($urandom_range(0, 399) != 0);
        step();
      end
    end

    idle_inputs();
    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/pcileech_ft601_emu.md
PCILEECH_FT601_EMU -- requirements
Module: pcileech_ft601_emu

Interface
REQ-001 SHALL have parameter PARAM_RX_DEPTH_LOG2, default 6, log2 of host->FPGA FIFO depth (range 2..10).
REQ-002 SHALL have parameter PARAM_TX_DEPTH_LOG2, default 6, log2 of FPGA->host FIFO depth (range 2..10).
REQ-003 SHALL have one clock and an asynchronous active-low reset, as follows.
REQ-004 clk  in  1  FT601 bus clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 ft601_rst_n  in  1  chip reset from FPGA; low = synchronous flush.
REQ-007 ft601_data_i  in  32  bus value driven by FPGA during writes.
REQ-008 ft601_be_i  in  4  byte enables driven by FPGA during writes.
REQ-009 ft601_data_o  out  32  bus value driven by emulator during reads.
REQ-010 ft601_data_oe  out  1  emulator drives bus; bench resolves inout.
REQ-011 ft601_rxf_n  out  1  low = read data available.
REQ-012 ft601_txe_n  out  1  low = write space available.
REQ-013 ft601_wr_n, ft601_rd_n, ft601_oe_n, ft601_siwu_n  in  1 each  FPGA strobes; siwu_n ignored.
REQ-014 host_rx_data/host_rx_valid/host_rx_ready  in/in/out  32/1/1  host->FPGA word stream.
REQ-015 host_tx_data/host_tx_be/host_tx_valid/host_tx_ready  out/out/out/in  32/4/1/1  FPGA->host word stream.
REQ-016 rx_word_count, tx_word_count  out  32 each  words transferred across the FT601 pads.
REQ-017 proto_err  out  1  sticky protocol-violation flag.

Function
REQ-018 RX FIFO: host push when host_rx_valid && host_rx_ready; host_rx_ready = RX count < depth (registered count).
REQ-019 RX pad pop on clk edge when ft601_oe_n==0 && ft601_rd_n==0 && ft601_rxf_n==0; one word per cycle, bursts unlimited.
REQ-020 ft601_data_o SHALL equal RX FIFO head combinationally; next word visible in the cycle after a pop.
REQ-021 ft601_data_oe SHALL be registered: 1 the cycle after a clk edge sampling ft601_oe_n==0, else 0.
REQ-022 ft601_rxf_n SHALL be registered = (next RX count == 0); goes high the cycle after the last word pops.
REQ-023 TX FIFO (36 bits, data+be): pad push on clk edge when ft601_wr_n==0 && ft601_txe_n==0.
REQ-024 ft601_txe_n SHALL be registered = (next TX count == depth); goes high the cycle after the FIFO fills.
REQ-025 host_tx_valid = TX count != 0; host pop when host_tx_valid && host_tx_ready.
REQ-026 Simultaneous push and pop on either FIFO SHALL leave count unchanged; pointers wrap modulo depth.
REQ-027 Push when full or pop when empty SHALL be ignored with no pointer/count change.
REQ-028 rx_word_count/tx_word_count SHALL increment by 1 per pad pop/push; wrap 0xFFFFFFFF -> 0.
REQ-029 proto_err SHALL set on any edge with ft601_wr_n==0 && ft601_oe_n==0, or ft601_rd_n==0 && ft601_oe_n==1; cleared only by reset.
REQ-030 Strobes sampled while rxf_n/txe_n high SHALL be ignored and SHALL NOT set proto_err.
REQ-031 ft601_rst_n==0 at an edge: both FIFOs emptied, counters zeroed, rxf_n=1, txe_n=1, host_rx_ready=0, data_oe=0; proto_err kept.

Reset
REQ-032 rst_n low SHALL immediately force: FIFO pointers/counts 0, rxf_n=1, txe_n=1, data_oe=0, host_rx_ready=0, host_tx_valid=0, counters 0, proto_err=0.
REQ-033 ft601_data_o SHALL be 0 in reset and whenever RX FIFO is empty.
REQ-034 First cycle after rst_n release with ft601_rst_n high: txe_n=0, rxf_n=1, host_rx_ready=1.
REQ-035 rst_n assertion mid-burst SHALL discard in-flight words; no partial word is delivered after release.

Verification
REQ-036 Host pushes 0x11111111,0x22222222,0x33333333; FPGA holds oe_n/rd_n low -> reads those 3 words in order; rxf_n high the cycle after the 3rd; rx_word_count=3.
REQ-037 FPGA writes 64 words (depth 64) with wr_n held low, host_tx_ready=0 -> txe_n high the cycle after word 64; 65th strobe ignored; tx_word_count=64.
REQ-038 TX FIFO full, host_tx_ready=1 and wr_n low together -> txe_n low again, count stays 63/64 per cycle, no word lost or duplicated across 200 words.
REQ-039 wr_n=0 with oe_n=0 for one cycle -> proto_err=1 and stays 1 until rst_n.
REQ-040 ft601_rst_n pulsed low with 10 words in each FIFO -> both empty, counters 0, rxf_n=1, host_tx_valid=0; rst_n low mid-burst -> all outputs at REQ-032 values asynchronously.
